button_conditioner: RTL and testbench

//  Turns raw push-button inputs into clean single-cycle events for the slot-machine control FSM.
//  Per channel: synchronises the asynchronous pin, debounces it and normalises polarity.

---
 rtl/button_pkg.sv | 19 +
 rtl/button_channel.sv | 149 ++++++++++++++
 rtl/button_conditioner.sv | 43 ++++
 tb/tb_button_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    BTN_RELEASED     = 2'd0,
    BTN_PRESS_PEND   = 2'd1,
    BTN_PRESSED      = 2'd2,
    BTN_RELEASE_PEND = 2'd3
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 500000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 50000000;

  function automatic bit fits_width(input longint unsigned value, input int width);
    if (width >= 64) return 1'b1;
    else return (value < (64'd1 << width));
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, registered polarity normalisation, debounce FSM,
// hold timer, registered press/release/long-press pulses.
module button_channel
  import button_pkg::*;
#(
  parameter int CNT_W             = 26,
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam logic             IDLE_PIN   = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam bit               DB_INSTANT = (DEBOUNCE_CYCLES <= 1);
  localparam bit               LP_EN      = (LONG_PRESS_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST    = DB_INSTANT ? '0 : CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_MAX     = LP_EN ? CNT_W'(LONG_PRESS_CYCLES) : '0;
  localparam logic [CNT_W-1:0] LP_FIRE    = LP_EN ? CNT_W'(LONG_PRESS_CYCLES - 1) : '0;

  logic             sync1_q, sync2_q, s_q;
  btn_state_t       state_q;
  logic [CNT_W-1:0] cnt_q, hold_q, hold_d;
  logic             level_q, press_q, release_q, long_q;
  logic             long_fire_s;

  // Synchroniser idles at the released pin level so reset exit is silent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= IDLE_PIN;
      sync2_q <= IDLE_PIN;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      s_q     <= sync2_q ^ IDLE_PIN;
    end
  end

  // Saturating hold timer step; stops at LONG_PRESS_CYCLES so long_press fires once.
  always_comb begin
    hold_d = hold_q;
    if (LP_EN && (hold_q < LP_MAX)) hold_d = hold_q + CNT_ONE;
    else hold_d = hold_q;
  end

  assign long_fire_s = LP_EN && (hold_q == LP_FIRE);

  // Debounce FSM with registered pulse outputs; hold keeps running through a release bounce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= BTN_RELEASED;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        BTN_RELEASED: begin
          hold_q <= '0;
          if (s_q && DB_INSTANT) begin
            state_q <= BTN_PRESSED;
            press_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
          end else if (s_q) begin
            state_q <= BTN_PRESS_PEND;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        BTN_PRESS_PEND: begin
          if (!s_q) begin
            state_q <= BTN_RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= BTN_PRESSED;
            press_q <= 1'b1;
            level_q <= 1'b1;
            hold_q  <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        BTN_PRESSED: begin
          if (!s_q && DB_INSTANT) begin
            state_q   <= BTN_RELEASED;
            release_q <= 1'b1;
            level_q   <= 1'b0;
            hold_q    <= '0;
            cnt_q     <= '0;
          end else if (!s_q) begin
            state_q <= BTN_RELEASE_PEND;
            cnt_q   <= CNT_ONE;
            hold_q  <= hold_d;
            long_q  <= long_fire_s;
          end else begin
            hold_q <= hold_d;
            long_q <= long_fire_s;
          end
        end
        BTN_RELEASE_PEND: begin
          if (s_q) begin
            state_q <= BTN_PRESSED;
            cnt_q   <= '0;
            hold_q  <= hold_d;
            long_q  <= long_fire_s;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= BTN_RELEASED;
            release_q <= 1'b1;
            level_q   <= 1'b0;
            hold_q    <= '0;
            cnt_q     <= '0;
          end else begin
            cnt_q  <= cnt_q + CNT_ONE;
            hold_q <= hold_d;
            long_q <= long_fire_s;
          end
        end
        default: begin
          state_q <= BTN_RELEASED;
          cnt_q   <= '0;
          hold_q  <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-button pins into debounced levels and single-cycle
// press / release / long-press events, one independent channel per button.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN             = 2,
  parameter int CNT_W             = 26,
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press
);

  if (!fits_width(longint'(DEBOUNCE_CYCLES), CNT_W) ||
      !fits_width(longint'(LONG_PRESS_CYCLES), CNT_W)) begin : g_param_err
    $error("button_conditioner: DEBOUNCE_CYCLES or LONG_PRESS_CYCLES does not fit in CNT_W");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .CNT_W            (CNT_W),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .BTN_ACTIVE_LOW   (BTN_ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn_raw[i]),
      .btn_level    (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected events are queued when a pin is
// driven and every cycle's outputs are checked against the events due that cycle.
module tb_button_conditioner;

  localparam int N   = 2;
  localparam int DB  = 4;
  localparam int LP  = 10;
  localparam int LAT = DB + 3;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;

  typedef struct {
    int at;
    int ch;
    int kind;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, press_pulse, release_pulse, long_press;

  ev_t          exp_q[$];
  logic [N-1:0] exp_level;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           c;

  button_conditioner #(
    .N_BTN            (N),
    .CNT_W            (8),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .BTN_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int at, input int ch, input int kind);
    ev_t e;
    e.at = at;
    e.ch = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic check_cycle();
    logic [N-1:0] ep, er, el;
    ep = '0;
    er = '0;
    el = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at == cyc) begin
        case (exp_q[i].kind)
          EV_PRESS:   begin ep[exp_q[i].ch] = 1'b1; exp_level[exp_q[i].ch] = 1'b1; end
          EV_RELEASE: begin er[exp_q[i].ch] = 1'b1; exp_level[exp_q[i].ch] = 1'b0; end
          default:    el[exp_q[i].ch] = 1'b1;
        endcase
        exp_q.delete(i);
      end
    end
    check("press_pulse", press_pulse, ep);
    check("release_pulse", release_pulse, er);
    check("long_press", long_press, el);
    check("btn_level", btn_level, exp_level);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_pin(input int ch);
    btn_raw[ch] = 1'b0;
    push(cyc + LAT, ch, EV_PRESS);
  endtask

  task automatic release_pin(input int ch);
    btn_raw[ch] = 1'b1;
    push(cyc + LAT, ch, EV_RELEASE);
  endtask

  initial begin
    reset     = 1'b0;
    btn_raw   = '1;
    exp_level = '0;
    ticks(3);
    reset = 1'b1;
    ticks(3);

    // clean press with long press, then clean release
    c = cyc;
    press_pin(0);
    push(c + LAT + LP, 0, EV_LONG);
    ticks(20);
    release_pin(0);
    ticks(12);

    // bounce shorter than the debounce window is discarded
    btn_raw[0] = 1'b0;
    ticks(3);
    btn_raw[0] = 1'b1;
    ticks(1);
    btn_raw[0] = 1'b0;
    ticks(3);
    btn_raw[0] = 1'b1;
    ticks(10);
    press_pin(0);
    ticks(4);
    release_pin(0);
    ticks(12);

    // long press on channel 1
    c = cyc;
    press_pin(1);
    push(c + LAT + LP, 1, EV_LONG);
    ticks(30);
    release_pin(1);
    ticks(12);

    // release glitch while pressed
    c = cyc;
    press_pin(0);
    push(c + LAT + LP, 0, EV_LONG);
    ticks(10);
    btn_raw[0] = 1'b1;
    ticks(2);
    btn_raw[0] = 1'b0;
    ticks(13);
    release_pin(0);
    ticks(12);

    // simultaneous presses on both channels
    c = cyc;
    press_pin(0);
    press_pin(1);
    push(c + LAT + LP, 0, EV_LONG);
    push(c + LAT + LP, 1, EV_LONG);
    ticks(15);
    release_pin(0);
    release_pin(1);
    ticks(12);

    // reset while pressed, pin held through reset exit
    press_pin(0);
    ticks(10);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_level", btn_level, '0);
    check("async_rst_press", press_pulse, '0);
    check("async_rst_release", release_pulse, '0);
    check("async_rst_long", long_press, '0);
    exp_q.delete();
    exp_level = '0;
    ticks(3);
    reset = 1'b1;
    push(cyc + LAT, 0, EV_PRESS);
    ticks(9);
    release_pin(0);
    ticks(12);

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL pending_events observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
